alu_exec_unit: RTL
==================

# alu_exec_unit

Registered execute-stage ALU that consumes the 4-bit `Operation` code produced by ALU control, together with the two register/immediate operands, and returns a result plus the branch flag used by the PC-select logic. Single-cycle operations complete with one cycle of latency. An optional shift-add multiplier takes WIDTH cycles. A start/ready/done handshake lets the control FSM stall while the multiplier is busy.

## Interface
- `WIDTH`, default 64: operand and result width.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only on a rising edge where `ready`=1.
- `operation`  in  4  ALU control code: 0010 add, 0110 sub, 0000 and, 0001 or, 1110 blt compare, 1000 mul (macro-gated).
- `a`  in  WIDTH  operand A; sampled at accept.
- `b`  in  WIDTH  operand B; sampled at accept.
- `ready`  out  1  unit idle and able to accept.
- `done`  out  1  one-cycle pulse; `result` and `zero` are valid.
- `result`  out  WIDTH  registered result; held until the next completion.
- `zero`  out  1  branch flag; registered with `result`.

## Operation
- FSM states: IDLE, MUL. Reset enters IDLE.
- IDLE with start=1 and a single-cycle op: compute, register `result`/`zero`, pulse `done`, remain in IDLE.
- add/sub/and/or: result = a op b, truncated modulo 2^WIDTH; zero = (result == 0).
- blt (1110): result = {0…, lt}, where lt = signed(a) < signed(b); zero = lt. The branch unit branches on `zero` for both beq and blt.
- Undefined codes: result = 0, zero = 1, `done` pulses normally, with no error flag.
- mul (1000, macro on): at accept, load multiplicand = a, multiplier = b, acc = 0, count = 0; go to MUL and drop `ready`.
- MUL iteration, once per cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. Arithmetic is modulo 2^WIDTH, so the result is the low WIDTH bits of the product and the operation is sign-agnostic.
- On the iteration where count reaches WIDTH-1: write result = final acc, zero = (result == 0), pulse `done`, raise `ready`, return to IDLE.
- `start` while `ready`=0 is ignored, not queued. Operand changes during MUL have no effect.
- Reset assertion at any time, including mid-multiply: FSM returns to IDLE immediately and the partial product is discarded.

## Timing
- Reset values: ready=1, done=0, result=0, zero=0, internal counters and accumulators 0.
- Single-cycle ops: accept at edge N gives `done`/`result` valid after edge N, i.e. latency 1. `ready` stays 1, so back-to-back accepts every cycle are legal.
- mul: accept at edge N; iterations at edges N+1 … N+WIDTH; `done`=1 and `ready`=1 after edge N+WIDTH. `ready`=0 from after edge N through edge N+WIDTH-1.
- A new start may be accepted on the same edge that `done` is high. The new `done` then follows per the rules above.
- `done` is never high for two consecutive cycles from a single accept.

## Configuration
- `ALU_MUL_EN` defined: the multiplier datapath and the MUL state are compiled in, and 1000 behaves as above.
- `ALU_MUL_EN` undefined: no multiplier logic. 1000 is treated as an undefined code (result 0, zero 1, 1-cycle latency), and `ready` is constant 1 after reset.

## Structure
- Shared package `alu_pkg`: the 4-bit operation code constants (ADD, SUB, AND, OR, BLT, MUL) and the FSM state enum. ALU control and this unit import the same constants.
- One sub-module: `alu_mul_seq`. It is a shift-add iterative multiplier with load/step/last ports and holds the multiplicand, multiplier, accumulator and counter. It is instantiated only under `ALU_MUL_EN`.

## Test plan
- Reset: hold reset_n=0 with random inputs. Expect ready=1, done=0, result=0, zero=0. Release, then issue add 5+7: result=12, zero=0, done after 1 edge.
- Sub 9-9: result=0, zero=1. blt a=-3, b=2: result=1, zero=1. blt a=2, b=-3: result=0, zero=0.
- Back-to-back: and 0xF0&0x3C, then or 0xF0|0x0F on consecutive edges. Expect done on 2 consecutive cycles with results 0x30, then 0xFF.
- Undefined op 0111: result=0, zero=1, done after 1 edge.
- (EN) mul 0xFFFF_FFFF × 3 with WIDTH=64: expect 0x2_FFFF_FFFD and ready=0 for exactly 64 edges. A start issued at iteration 10 is ignored. Also check -1 × -1 gives 1.
- (EN) Assert reset_n at iteration 30 of a multiply: expect ready=1, done=0, result=0 immediately. The next add must complete normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control operation codes and execute-unit FSM states shared with ALU control.
package alu_pkg;
  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] AND = 4'b0000;
  localparam logic [3:0] OR  = 4'b0001;
  localparam logic [3:0] BLT = 4'b1110;
  localparam logic [3:0] MUL = 4'b1000;
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one partial product per step, low WIDTH bits kept.
module alu_mul_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_acc_next
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
  logic [CW-1:0]    r_count;
  // o_acc_next already includes the current step, so the final product is visible on the last step
  assign o_acc_next = r_mplier[0] ? r_acc + r_mcand : r_acc;
  assign o_last     = r_count == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_step) begin
      r_acc    <= o_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute-stage ALU with start/ready/done handshake.
// Define ALU_MUL_EN to build in the WIDTH-cycle shift-add multiplier for code 1000.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  logic             w_accept, w_lt, w_zero, w_load, w_fin, r_done, r_zero;
  logic [WIDTH-1:0] w_res, w_prod, r_result;
  assign w_accept = start & ready;
  assign w_lt     = $signed(a) < $signed(b);
  // blt reports through zero so the branch unit uses one flag for beq and blt
  always_comb begin
    w_res  = operation == ADD ? a + b :
             operation == SUB ? a - b :
             operation == AND ? a & b :
             operation == OR  ? a | b :
             operation == BLT ? {{(WIDTH-1){1'b0}}, w_lt} : '0;
    w_zero = operation == BLT ? w_lt : w_res == '0;
  end
`ifdef ALU_MUL_EN
  alu_state_e r_state;
  logic       w_last;
  assign ready  = r_state == ST_IDLE;
  assign w_load = w_accept & (operation == MUL);
  assign w_fin  = (r_state == ST_MUL) & w_last;
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_load),
    .i_step    (r_state == ST_MUL),
    .i_a       (a),
    .i_b       (b),
    .o_last    (w_last),
    .o_acc_next(w_prod)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else r_state <= w_load ? ST_MUL : w_fin ? ST_IDLE : r_state;
  end
`else
  assign ready  = 1'b1;
  assign w_load = 1'b0;
  assign w_fin  = 1'b0;
  assign w_prod = '0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= w_fin | (w_accept & ~w_load);
      if (w_fin) begin
        r_result <= w_prod;
        r_zero   <= w_prod == '0;
      end else if (w_accept & ~w_load) begin
        r_result <= w_res;
        r_zero   <= w_zero;
      end
    end
  end
  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;
endmodule
